// File: rtl/dbus_wb_if.sv
// Wishbone B3 classic single-beat master for the OpenMIPS data port.
// Holds stallreq until ack/abort and returns load data to MEM/WB.
module dbus_wb_if #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic        cpu_ce_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_data_i,
  input  logic        cpu_we_i,
  input  logic [3:0]  cpu_sel_i,
  output logic [31:0] cpu_data_o,
  output logic        stallreq,
  output logic        bus_err_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  localparam logic [1:0] StIdle      = 2'd0;
  localparam logic [1:0] StBusy      = 2'd1;
  localparam logic [1:0] StWaitStall = 2'd2;

  // Wraps harmlessly when TIMEOUT is 0; the compare is gated off in that case.
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [31:0]      wb_adr_q, wb_adr_d;
  logic [31:0]      wb_dat_q, wb_dat_d;
  logic [3:0]       wb_sel_q, wb_sel_d;
  logic             wb_we_q, wb_we_d;
  logic             wb_cyc_q, wb_cyc_d;
  logic [31:0]      rd_buf_q, rd_buf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_err_q, bus_err_d;

  logic stall_any;
  logic timeout_hit;
  logic clear_bus;

  assign stall_any   = |stall;
  assign timeout_hit = (TIMEOUT != 0) && (state_q == StBusy) && (cnt_q == CntLast);

  always_comb begin
    state_d   = state_q;
    wb_adr_d  = wb_adr_q;
    wb_dat_d  = wb_dat_q;
    wb_sel_d  = wb_sel_q;
    wb_we_d   = wb_we_q;
    wb_cyc_d  = wb_cyc_q;
    rd_buf_d  = rd_buf_q;
    cnt_d     = cnt_q;
    bus_err_d = 1'b0;
    clear_bus = 1'b0;

    case (state_q)
      StIdle: begin
        if (cpu_ce_i && !flush) begin
          wb_adr_d = cpu_addr_i;
          wb_dat_d = cpu_data_i;
          wb_sel_d = cpu_sel_i;
          wb_we_d  = cpu_we_i;
          wb_cyc_d = 1'b1;
          cnt_d    = '0;
          state_d  = StBusy;
        end else begin
          clear_bus = 1'b1;
        end
      end
      StBusy: begin
        // Flush wins over a same-cycle ack so the faulting access never returns data.
        if (flush) begin
          clear_bus = 1'b1;
          rd_buf_d  = '0;
          state_d   = StIdle;
        end else if (wb_ack_i) begin
          clear_bus = 1'b1;
          rd_buf_d  = wb_dat_i;
          state_d   = stall_any ? StWaitStall : StIdle;
        end else if (timeout_hit) begin
          clear_bus = 1'b1;
          rd_buf_d  = '0;
          bus_err_d = 1'b1;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StWaitStall: begin
        if (flush) begin
          rd_buf_d = '0;
          state_d  = StIdle;
        end else if (!stall_any) begin
          state_d = StIdle;
        end
      end
      default: begin
        clear_bus = 1'b1;
        state_d   = StIdle;
      end
    endcase

    if (clear_bus) begin
      wb_adr_d = '0;
      wb_dat_d = '0;
      wb_sel_d = '0;
      wb_we_d  = 1'b0;
      wb_cyc_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      wb_adr_q  <= '0;
      wb_dat_q  <= '0;
      wb_sel_q  <= '0;
      wb_we_q   <= 1'b0;
      wb_cyc_q  <= 1'b0;
      rd_buf_q  <= '0;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wb_adr_q  <= wb_adr_d;
      wb_dat_q  <= wb_dat_d;
      wb_sel_q  <= wb_sel_d;
      wb_we_q   <= wb_we_d;
      wb_cyc_q  <= wb_cyc_d;
      rd_buf_q  <= rd_buf_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    stallreq   = 1'b0;
    cpu_data_o = '0;
    if (!rst) begin
      if (state_q == StIdle) begin
        stallreq = cpu_ce_i && !flush;
      end else if (state_q == StBusy) begin
        stallreq = !wb_ack_i && !flush && !timeout_hit;
        if (wb_ack_i && !flush) begin
          cpu_data_o = wb_dat_i;
        end
      end else if (state_q == StWaitStall) begin
        cpu_data_o = rd_buf_q;
      end
    end
  end

  assign wb_adr_o  = wb_adr_q;
  assign wb_dat_o  = wb_dat_q;
  assign wb_sel_o  = wb_sel_q;
  assign wb_we_o   = wb_we_q;
  assign wb_cyc_o  = wb_cyc_q;
  assign wb_stb_o  = wb_cyc_q;
  assign bus_err_o = bus_err_q;

endmodule

// File: tb/tb_dbus_wb_if.sv
// Directed bench for dbus_wb_if: load/store, stall hold, flush, timeout, async reset.
module tb_dbus_wb_if;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        cpu_ce_i;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_data_i;
  logic        cpu_we_i;
  logic [3:0]  cpu_sel_i;
  logic [31:0] cpu_data_o;
  logic        stallreq;
  logic        bus_err_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;

  // Second instance with a short timeout; its bus never acks.
  logic        to_ce;
  logic        to_ack;
  logic [31:0] to_data_o;
  logic        to_stallreq;
  logic        to_bus_err;
  logic [31:0] to_adr;
  logic [31:0] to_dat;
  logic [3:0]  to_sel;
  logic        to_we;
  logic        to_cyc;
  logic        to_stb;

  int n_tests = 0;
  int n_fail  = 0;
  int sr_cnt;
  int err_cnt;

  always #5 clk = ~clk;

  dbus_wb_if u_dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .flush     (flush),
    .cpu_ce_i  (cpu_ce_i),
    .cpu_addr_i(cpu_addr_i),
    .cpu_data_i(cpu_data_i),
    .cpu_we_i  (cpu_we_i),
    .cpu_sel_i (cpu_sel_i),
    .cpu_data_o(cpu_data_o),
    .stallreq  (stallreq),
    .bus_err_o (bus_err_o),
    .wb_adr_o  (wb_adr_o),
    .wb_dat_o  (wb_dat_o),
    .wb_sel_o  (wb_sel_o),
    .wb_we_o   (wb_we_o),
    .wb_cyc_o  (wb_cyc_o),
    .wb_stb_o  (wb_stb_o),
    .wb_dat_i  (wb_dat_i),
    .wb_ack_i  (wb_ack_i)
  );

  dbus_wb_if #(
    .TIMEOUT(4),
    .CNT_W  (3)
  ) u_dut_to (
    .clk       (clk),
    .rst       (rst),
    .stall     (6'b0),
    .flush     (1'b0),
    .cpu_ce_i  (to_ce),
    .cpu_addr_i(32'h0000_0080),
    .cpu_data_i(32'h0),
    .cpu_we_i  (1'b0),
    .cpu_sel_i (4'hF),
    .cpu_data_o(to_data_o),
    .stallreq  (to_stallreq),
    .bus_err_o (to_bus_err),
    .wb_adr_o  (to_adr),
    .wb_dat_o  (to_dat),
    .wb_sel_o  (to_sel),
    .wb_we_o   (to_we),
    .wb_cyc_o  (to_cyc),
    .wb_stb_o  (to_stb),
    .wb_dat_i  (32'h1111_2222),
    .wb_ack_i  (to_ack)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  initial begin
    rst        = 1'b1;
    stall      = 6'b0;
    flush      = 1'b0;
    cpu_ce_i   = 1'b1;
    cpu_addr_i = 32'h0000_0040;
    cpu_data_i = 32'h0;
    cpu_we_i   = 1'b0;
    cpu_sel_i  = 4'hF;
    wb_dat_i   = 32'h0;
    wb_ack_i   = 1'b0;
    to_ce      = 1'b0;
    to_ack     = 1'b0;

    // Reset state: outputs zero, comb stallreq masked even with ce high.
    tick;
    settle;
    check("rst_cyc", {31'b0, wb_cyc_o}, 32'h0);
    check("rst_stallreq", {31'b0, stallreq}, 32'h0);
    check("rst_bus", {wb_adr_o | wb_dat_o}, 32'h0);
    check("rst_err", {31'b0, bus_err_o}, 32'h0);
    cpu_ce_i = 1'b0;
    tick;
    rst = 1'b0;
    tick;

    // 1. Load, ack on the 4th cycle of stb: stallreq high for 4 cycles.
    sr_cnt   = 0;
    cpu_ce_i = 1'b1;
    settle;
    if (stallreq) sr_cnt++;
    for (int k = 1; k <= 4; k++) begin
      tick;
      if (k == 4) begin
        wb_ack_i = 1'b1;
        wb_dat_i = 32'hDEAD_BEEF;
      end
      settle;
      if (k == 1) begin
        check("ld_cyc", {30'b0, wb_cyc_o, wb_stb_o}, 32'h3);
        check("ld_adr", wb_adr_o, 32'h0000_0040);
      end
      if (k == 4) check("ld_data", cpu_data_o, 32'hDEAD_BEEF);
      if (stallreq) sr_cnt++;
    end
    check("ld_stall_cycles", sr_cnt, 32'd4);
    tick;
    wb_ack_i = 1'b0;
    wb_dat_i = 32'h0;
    cpu_ce_i = 1'b0;
    settle;
    check("ld_idle_cyc", {31'b0, wb_cyc_o}, 32'h0);
    check("ld_idle_data", cpu_data_o, 32'h0);

    // 2. Store: bus stable until ack, all zero afterwards.
    cpu_ce_i   = 1'b1;
    cpu_we_i   = 1'b1;
    cpu_addr_i = 32'h0000_0100;
    cpu_sel_i  = 4'b0011;
    cpu_data_i = 32'h0000_1234;
    for (int k = 1; k <= 3; k++) begin
      tick;
      if (k == 3) wb_ack_i = 1'b1;
      settle;
      check("st_ctl", {28'b0, wb_we_o, wb_sel_o[1:0], wb_cyc_o}, 32'hF);
      check("st_sel", {28'b0, wb_sel_o}, 32'h3);
      check("st_adr", wb_adr_o, 32'h0000_0100);
      check("st_dat", wb_dat_o, 32'h0000_1234);
    end
    tick;
    wb_ack_i = 1'b0;
    cpu_ce_i = 1'b0;
    cpu_we_i = 1'b0;
    settle;
    check("st_after_ctl", {25'b0, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}, 32'h0);
    check("st_after_bus", wb_adr_o | wb_dat_o, 32'h0);

    // 3. Ack while another unit stalls: data held until stall clears.
    cpu_ce_i   = 1'b1;
    cpu_addr_i = 32'h0000_0200;
    cpu_sel_i  = 4'hF;
    tick;
    stall    = 6'b001111;
    wb_ack_i = 1'b1;
    wb_dat_i = 32'hA5A5_5A5A;
    settle;
    check("ws_ack_data", cpu_data_o, 32'hA5A5_5A5A);
    for (int k = 0; k < 2; k++) begin
      tick;
      wb_ack_i = 1'b0;
      wb_dat_i = 32'h0;
      settle;
      check("ws_hold_data", cpu_data_o, 32'hA5A5_5A5A);
      check("ws_hold_sr", {31'b0, stallreq}, 32'h0);
      check("ws_hold_cyc", {31'b0, wb_cyc_o}, 32'h0);
    end
    stall = 6'b0;
    settle;
    check("ws_release_data", cpu_data_o, 32'hA5A5_5A5A);
    tick;
    cpu_ce_i = 1'b0;
    settle;
    check("ws_idle_data", cpu_data_o, 32'h0);

    // Ack outside BUSY is ignored.
    wb_ack_i = 1'b1;
    wb_dat_i = 32'h5555_5555;
    settle;
    check("idle_ack_data", cpu_data_o, 32'h0);
    tick;
    wb_ack_i = 1'b0;
    settle;
    check("idle_ack_cyc", {31'b0, wb_cyc_o}, 32'h0);

    // 4. Flush together with ack in BUSY: nothing returned.
    cpu_ce_i = 1'b1;
    tick;
    flush    = 1'b1;
    wb_ack_i = 1'b1;
    wb_dat_i = 32'hCAFE_F00D;
    settle;
    check("fl_data", cpu_data_o, 32'h0);
    check("fl_sr", {31'b0, stallreq}, 32'h0);
    tick;
    flush    = 1'b0;
    wb_ack_i = 1'b0;
    cpu_ce_i = 1'b0;
    settle;
    check("fl_cyc", {30'b0, wb_cyc_o, wb_stb_o}, 32'h0);
    check("fl_after_data", cpu_data_o, 32'h0);

    // Flush in IDLE suppresses issue.
    cpu_ce_i = 1'b1;
    flush    = 1'b1;
    settle;
    check("fl_idle_sr", {31'b0, stallreq}, 32'h0);
    tick;
    cpu_ce_i = 1'b0;
    flush    = 1'b0;
    settle;
    check("fl_idle_cyc", {31'b0, wb_cyc_o}, 32'h0);

    // 5. TIMEOUT=4 with no ack: stallreq falls on the 4th BUSY cycle, one err pulse next.
    to_ce = 1'b1;
    tick;
    to_ce   = 1'b0;
    err_cnt = 0;
    for (int k = 1; k <= 6; k++) begin
      settle;
      check($sformatf("to_sr_%0d", k), {31'b0, to_stallreq}, {31'b0, (k <= 3)});
      check($sformatf("to_cyc_%0d", k), {30'b0, to_cyc, to_stb},
            (k <= 4) ? 32'h3 : 32'h0);
      check($sformatf("to_err_%0d", k), {31'b0, to_bus_err}, {31'b0, (k == 5)});
      if (to_bus_err) err_cnt++;
      tick;
    end
    check("to_err_pulses", err_cnt, 32'd1);

    // 6. Async reset mid-BUSY, then a fresh cycle.
    cpu_ce_i   = 1'b1;
    cpu_addr_i = 32'h0000_0300;
    tick;
    settle;
    check("rb_cyc_before", {31'b0, wb_cyc_o}, 32'h1);
    rst = 1'b1;
    #1;
    check("rb_cyc_async", {31'b0, wb_cyc_o}, 32'h0);
    check("rb_sr_async", {31'b0, stallreq}, 32'h0);
    cpu_ce_i = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    tick;
    settle;
    check("rb_no_retry", {31'b0, wb_cyc_o}, 32'h0);
    cpu_ce_i   = 1'b1;
    cpu_addr_i = 32'h0000_0400;
    tick;
    settle;
    check("rb_fresh_cyc", {31'b0, wb_cyc_o}, 32'h1);
    check("rb_fresh_adr", wb_adr_o, 32'h0000_0400);
    wb_ack_i = 1'b1;
    wb_dat_i = 32'h0BAD_CAFE;
    settle;
    check("rb_fresh_data", cpu_data_o, 32'h0BAD_CAFE);
    tick;
    wb_ack_i = 1'b0;
    cpu_ce_i = 1'b0;
    settle;
    check("rb_done_cyc", {31'b0, wb_cyc_o}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
